// File: rtl/addsub_pkg.sv
// Shared op encodings, result record and overflow helper for the 4-bit add/sub datapath.
package addsub_pkg;

    localparam int unsigned ADDSUB_W = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic [ADDSUB_W-1:0] s;
        logic                c;
        logic                z;
        logic                n;
        logic                v;
    } addsub_res_t;

    // Subtract flips b's sign, so overflow needs operand signs to differ instead of match.
    function automatic logic calc_v(input op_e sel, input logic a_msb, input logic b_msb,
                                    input logic s_msb);
        if (sel == OP_ADD) begin
            return (a_msb == b_msb) && (s_msb != a_msb);
        end
        return (a_msb != b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_flag_calc.sv
// Combinational Z/N/V flag derivation for one adder result.
module addsub_flag_calc
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_sel,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             z,
    output logic             n,
    output logic             v
);

    always_comb begin
        z = (in_s == '0);
        n = in_s[WIDTH-1];
        v = calc_v(op_e'(in_sel), a_msb, b_msb, in_s[WIDTH-1]);
    end

endmodule

// File: rtl/addsub_result_buffer.sv
// Result FIFO with flag capture and valid/ready delivery for the add/sub datapath.
// Optional STICKY_OVF_EN adds a sticky signed-overflow indicator (clr_sticky / sticky_v).
module addsub_result_buffer
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_s,
    input  logic                         in_cout,
    input  logic                         in_sel,
    input  logic                         in_a_msb,
    input  logic                         in_b_msb,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_s,
    output logic                         out_c,
    output logic                         out_z,
    output logic                         out_n,
    output logic                         out_v,
`ifdef STICKY_OVF_EN
    input  logic                         clr_sticky,
    output logic                         sticky_v,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             z;
        logic             n;
        logic             v;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            push;
    logic            pop;
    logic            flag_z;
    logic            flag_n;
    logic            flag_v;

    addsub_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
        .in_s  (in_s),
        .in_sel(in_sel),
        .a_msb (in_a_msb),
        .b_msb (in_b_msb),
        .z     (flag_z),
        .n     (flag_n),
        .v     (flag_v)
    );

    // in_ready depends on registered count only, so a full buffer never accepts even on a pop.
    always_comb begin
        in_ready  = (cnt < CW'(DEPTH));
        out_valid = (cnt != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        head      = mem[rd_ptr];
        out_s     = head.s;
        out_c     = head.c;
        out_z     = head.z;
        out_n     = head.n;
        out_v     = head.v;
        count     = cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{s: in_s, c: in_cout, z: flag_z, n: flag_n, v: flag_v};
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef STICKY_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_v <= 1'b0;
        end else if (push && flag_v) begin
            sticky_v <= 1'b1;
        end else if (clr_sticky) begin
            sticky_v <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_addsub_result_buffer.sv
// Directed self-checking bench for addsub_result_buffer (WIDTH=4, DEPTH=2).
module tb_addsub_result_buffer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_s;
    logic       in_cout;
    logic       in_sel;
    logic       in_a_msb;
    logic       in_b_msb;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_s;
    logic       out_c;
    logic       out_z;
    logic       out_n;
    logic       out_v;
    logic [1:0] count;
`ifdef STICKY_OVF_EN
    logic       clr_sticky;
    logic       sticky_v;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    addsub_result_buffer #(.WIDTH(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_s      (in_s),
        .in_cout   (in_cout),
        .in_sel    (in_sel),
        .in_a_msb  (in_a_msb),
        .in_b_msb  (in_b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_s     (out_s),
        .out_c     (out_c),
        .out_z     (out_z),
        .out_n     (out_n),
        .out_v     (out_v),
`ifdef STICKY_OVF_EN
        .clr_sticky(clr_sticky),
        .sticky_v  (sticky_v),
`endif
        .count     (count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic c, input logic sel,
                         input logic a, input logic b);
        in_valid = v;
        in_s     = s;
        in_cout  = c;
        in_sel   = sel;
        in_a_msb = a;
        in_b_msb = b;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef STICKY_OVF_EN
        clr_sticky = 1'b0;
`endif
        #12;
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if ({out_s, out_c, out_z, out_n, out_v} !== 8'h00) begin fails++; $display("FAIL reset_outputs got %h want 00", {out_s, out_c, out_z, out_n, out_v}); end
`ifdef STICKY_OVF_EN
        checks++; if (sticky_v !== 1'b0) begin fails++; $display("FAIL reset_sticky got %b want 0", sticky_v); end
`endif
    endtask

    task automatic test_add_basic();
        out_ready = 1'b0;
        drive(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_out_valid got %b want 1", out_valid); end
        checks++; if ({out_s, out_c, out_z, out_n, out_v} !== {4'b0011, 4'b0000}) begin fails++; $display("FAIL add_entry got %b want 00110000", {out_s, out_c, out_z, out_n, out_v}); end
        checks++; if (count !== 2'd1) begin fails++; $display("FAIL add_count got %0d want 1", count); end
        tick();
        checks++; if (out_s !== 4'b0011) begin fails++; $display("FAIL add_stall_hold got %b want 0011", out_s); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL add_pop got count %0d valid %b want 0 0", count, out_valid); end
    endtask

    task automatic test_flags();
        out_ready = 1'b0;
        drive(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if ({out_s, out_c, out_z, out_n, out_v} !== {4'b1000, 4'b0011}) begin fails++; $display("FAIL flags_add_ovf got %b want 10000011", {out_s, out_c, out_z, out_n, out_v}); end
        // pop the overflow entry while pushing the zero-result subtract
        out_ready = 1'b1;
        drive(1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (count !== 2'd1) begin fails++; $display("FAIL flags_pushpop_count got %0d want 1", count); end
        checks++; if ({out_s, out_c, out_z, out_n, out_v} !== {4'b0000, 4'b1100}) begin fails++; $display("FAIL flags_sub_zero got %b want 00001100", {out_s, out_c, out_z, out_n, out_v}); end
        // 0111 - 1001 = 7 - (-7): signed overflow on subtract
        drive(1'b1, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checks++; if ({out_s, out_c, out_z, out_n, out_v} !== {4'b1110, 4'b0011}) begin fails++; $display("FAIL flags_sub_ovf got %b want 11100011", {out_s, out_c, out_z, out_n, out_v}); end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin fails++; $display("FAIL flags_drain got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin fails++; $display("FAIL b2b_full got count %0d ready %b want 2 0", count, in_ready); end
        tick();
        checks++; if (count !== 2'd2 || out_s !== 4'd1) begin fails++; $display("FAIL b2b_held got count %0d s %0d want 2 1", count, out_s); end
        out_ready = 1'b1;
        tick();
        checks++; if (count !== 2'd1 || out_s !== 4'd2) begin fails++; $display("FAIL b2b_pop_no_push got count %0d s %0d want 1 2", count, out_s); end
        out_ready = 1'b0;
        tick();
        checks++; if (count !== 2'd2 || out_s !== 4'd2) begin fails++; $display("FAIL b2b_third_in got count %0d s %0d want 2 2", count, out_s); end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        checks++; if (count !== 2'd1 || out_s !== 4'd5) begin fails++; $display("FAIL b2b_order got count %0d s %0d want 1 5", count, out_s); end
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got count %0d valid %b want 0 0", count, out_valid); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        drive(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 4'(7 + i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            checks++; if (count !== 2'd1 || out_s !== 4'(7 + i)) begin fails++; $display("FAIL wrap_%0d got count %0d s %0d want 1 %0d", i, count, out_s, 7 + i); end
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin fails++; $display("FAIL wrap_drain got %0d want 0", count); end
    endtask

    task automatic test_reset_midrun();
        out_ready = 1'b0;
        drive(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (count !== 2'd2 || out_s !== 4'd9) begin fails++; $display("FAIL midrun_preload got count %0d s %0d want 2 9", count, out_s); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || count !== 2'd0 || out_s !== 4'd0) begin fails++; $display("FAIL midrun_async got valid %b count %0d s %0d want 0 0 0", out_valid, count, out_s); end
        #4;
        rst_n = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL midrun_release got valid %b ready %b want 0 1", out_valid, in_ready); end
    endtask

`ifdef STICKY_OVF_EN
    task automatic test_sticky();
        out_ready  = 1'b0;
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        drive(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (sticky_v !== 1'b1) begin fails++; $display("FAIL sticky_set got %b want 1", sticky_v); end
        clr_sticky = 1'b1;
        tick();
        checks++; if (sticky_v !== 1'b0) begin fails++; $display("FAIL sticky_clear got %b want 0", sticky_v); end
        drive(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clr_sticky = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (sticky_v !== 1'b1) begin fails++; $display("FAIL sticky_set_wins got %b want 1", sticky_v); end
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 2'd0) begin fails++; $display("FAIL sticky_drain got %0d want 0", count); end
    endtask
`endif

    initial begin
        test_reset();
        test_add_basic();
        test_flags();
        test_back_to_back();
        test_wrap();
        test_reset_midrun();
`ifdef STICKY_OVF_EN
        test_sticky();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
